instr_prefetch_buffer: RTL and testbench



---
 rtl/instr_prefetch_buffer.sv | 131 +++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding imem read at a time,
// results buffered with their PC in a DEPTH-entry FIFO; redirect flushes and refetches.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [15:0]                imem_addr,
    input  logic                       imem_rvalid,
    input  logic [15:0]                imem_rdata,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [15:0]                instr_data,
    output logic [15:0]                instr_pc,
    input  logic                       redirect,
    input  logic [15:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        fetch_pc_q, fetch_pc_d;
    logic [15:0]        req_addr_q, req_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [15:0]        data_mem [DEPTH];
    logic [15:0]        pc_mem   [DEPTH];

    logic               issue_c;
    logic               push_c;
    logic               pop_c;

    // Next-state: redirect overrides everything, including same-cycle push/pop.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        issue_c    = (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && !redirect;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // A response landing this cycle retires the outstanding read.
            if ((state_q == WAIT) || (state_q == DISCARD)) begin
                state_d = imem_rvalid ? IDLE : DISCARD;
            end else begin
                state_d = IDLE;
            end
        end else begin
            pop_c = (count_q != '0) && instr_ready;
            case (state_q)
                IDLE: begin
                    if (issue_c) begin
                        req_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 16'(PC_STEP);
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        push_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
            count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            data_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= req_addr_q;
        end
    end

    assign imem_req    = issue_c;
    assign imem_addr   = (state_q == IDLE) ? fetch_pc_q : req_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = instr_valid ? data_mem[rd_ptr_q] : 16'h0000;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : 16'h0000;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized bench for instr_prefetch_buffer against a queue-based model of
// the prefetch rules, plus directed scenarios for redirect, wrap and reset.
module tb_instr_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [2:0]  fifo_count;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_STEP(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } ent_t;

    // Reference model: buffered entries plus the fetch/outstanding-read status.
    ent_t        mq[$];
    logic [15:0] m_fetch;
    logic [15:0] m_out_addr;
    bit          m_wait;
    bit          m_disc;

    // Memory responder: arrival-ordered pending reads.
    int          due_t[$];
    logic [15:0] due_a[$];
    logic [15:0] issued[$];
    int          cyc_n;
    int          lat_fix;
    bit          lat_rand;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h5121;
        if (a == 16'h0002) return 16'h6332;
        return (a * 16'h9E37) ^ 16'h3C5A;
    endfunction

    // One clock: drive inputs, compare outputs with model, advance model.
    task automatic step(input bit rst, input bit redir, input logic [15:0] rpc, input bit rdy);
        bit          exp_req;
        bit          issue;
        logic [15:0] exp_data;
        logic [15:0] exp_pc;
        @(negedge clk);
        reset       = rst;
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = rdy;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        if (due_t.size() > 0 && due_t[0] <= cyc_n) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(due_a[0]);
            void'(due_t.pop_front());
            void'(due_a.pop_front());
        end
        #1;
        exp_req  = !m_wait && !m_disc && (mq.size() < DEPTH) && !redir;
        exp_data = (mq.size() > 0) ? mq[0].data : 16'h0000;
        exp_pc   = (mq.size() > 0) ? mq[0].pc   : 16'h0000;
        check("fifo_count",  32'(fifo_count),  32'(mq.size()));
        check("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        check("instr_data",  32'(instr_data),  32'(exp_data));
        check("instr_pc",    32'(instr_pc),    32'(exp_pc));
        check("imem_req",    32'(imem_req),    32'(exp_req));
        if (exp_req)     check("imem_addr_req",  32'(imem_addr), 32'(m_fetch));
        else if (m_wait) check("imem_addr_hold", 32'(imem_addr), 32'(m_out_addr));

        if (imem_req && !rst) begin
            due_t.push_back(cyc_n + (lat_rand ? int'($urandom_range(1, 4)) : lat_fix));
            due_a.push_back(imem_addr);
            issued.push_back(imem_addr);
        end

        if (rst) begin
            mq.delete();
            m_fetch = 16'h0000;
            m_wait  = 1'b0;
            m_disc  = 1'b0;
        end else if (redir) begin
            mq.delete();
            m_fetch = rpc;
            m_disc  = (m_wait || m_disc) && !imem_rvalid;
            m_wait  = 1'b0;
        end else begin
            issue = !m_wait && !m_disc && (mq.size() < DEPTH);
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (m_wait) begin
                if (imem_rvalid) begin
                    mq.push_back('{pc: m_out_addr, data: imem_rdata});
                    m_wait = 1'b0;
                end
            end else if (m_disc) begin
                if (imem_rvalid) m_disc = 1'b0;
            end else if (issue) begin
                m_out_addr = m_fetch;
                m_fetch    = m_fetch + 16'd2;
                m_wait     = 1'b1;
            end
        end
        cyc_n++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        n_cmp = 0; n_err = 0; cyc_n = 0;
        lat_fix = 1; lat_rand = 1'b0;
        m_fetch = 16'h0000; m_out_addr = 16'h0000; m_wait = 1'b0; m_disc = 1'b0;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
        instr_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
        repeat (2) @(posedge clk);

        // Basic streaming, latency 1
        do_reset(2);
        issued.delete();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("s1_nreq", 32'(issued.size() >= 3), 32'd1);
        if (issued.size() >= 3) begin
            check("s1_addr0", 32'(issued[0]), 32'h0000);
            check("s1_addr1", 32'(issued[1]), 32'h0002);
            check("s1_addr2", 32'(issued[2]), 32'h0004);
        end

        // Back-pressure fills the FIFO, one pop frees one credit
        do_reset(2);
        issued.delete();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        check("s2_full_reqs", 32'(issued.size()), 32'd4);
        check("s2_full_cnt",  32'(fifo_count), 32'd4);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        check("s2_after_pop_reqs", 32'(issued.size()), 32'd5);
        if (issued.size() == 5) check("s2_next_addr", 32'(issued[4]), 32'h0008);

        // Redirect while waiting on a slow response
        do_reset(2);
        lat_fix = 3;
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        issued.delete();
        step(1'b0, 1'b1, 16'h0040, 1'b1);
        check("s3_flush_cnt", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("s3_nreq", 32'(issued.size() > 0), 32'd1);
        if (issued.size() > 0) check("s3_addr", 32'(issued[0]), 32'h0040);

        // Redirect coincident with rvalid and a pop, FIFO non-empty
        do_reset(2);
        lat_fix = 2;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (due_t.size() > 0 && due_t[0] <= cyc_n && mq.size() > 0) begin
                issued.delete();
                step(1'b0, 1'b1, 16'h1230, 1'b1);
                hit = 1'b1;
            end else begin
                step(1'b0, 1'b0, 16'h0000, 1'b0);
            end
        end
        check("s4_reached", 32'(hit), 32'd1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("s4_nreq", 32'(issued.size()), 32'd1);
        if (issued.size() > 0) check("s4_addr", 32'(issued[0]), 32'h1230);

        // Address wrap at the top of memory
        lat_fix = 1;
        step(1'b0, 1'b1, 16'hFFFC, 1'b1);
        issued.delete();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("s5_nreq", 32'(issued.size() >= 3), 32'd1);
        if (issued.size() >= 3) begin
            check("s5_addr0", 32'(issued[0]), 32'hFFFC);
            check("s5_addr1", 32'(issued[1]), 32'hFFFE);
            check("s5_addr2", 32'(issued[2]), 32'h0000);
        end

        // Reset while a read is outstanding; its response lands during reset
        do_reset(2);
        lat_fix = 3;
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        do_reset(3);
        issued.delete();
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("s6_cnt", 32'(fifo_count), 32'd0);
        check("s6_nreq", 32'(issued.size()), 32'd1);
        if (issued.size() > 0) check("s6_addr", 32'(issued[0]), 32'h0000);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);

        // Random traffic
        lat_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 15) == 0),
                 16'($urandom) & 16'hFFFE,
                 ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
